// File: rtl/sid_bus_master.sv
// SID bus master: queues CPU writes, services one pending read, and
// sequences SID chip-select/write strobes against a free-running 1 MHz
// sid_clk derived from the 32 MHz system clock.
module sid_bus_master #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CS_START   = 20
) (
    input  logic       clk32,
    input  logic       rst_n,
    input  logic       wr_stb,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       rd_stb,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       rd_done,
    output logic       n_wait,
    output logic       fifo_full,
    output logic       fifo_empty,
    output logic       overflow,
    output logic       sid_clk,
    output logic       sid_rst,
    output logic [4:0] sid_a,
    output logic [7:0] sid_d_out,
    output logic       sid_d_oe,
    input  logic [7:0] sid_d_in,
    output logic       sid_cs,
    output logic       sid_wr
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] C_ONE    = CW'(1);
    localparam logic [PW-1:0] P_ONE    = PW'(1);
    localparam logic [4:0]    CS_CNT   = 5'(CS_START);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ARM, S_ACTIVE, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [4:0]    cnt_q, cnt_d;
    logic [12:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] ahead_q, ahead_d;
    logic          rd_pend_q, rd_pend_d;
    logic [4:0]    rd_addr_q;
    logic          op_rd_q;
    logic [4:0]    op_a_q;
    logic [7:0]    op_d_q;
    logic [7:0]    rd_data_q;
    logic          rd_done_q, n_wait_q, overflow_q;
    logic [4:0]    sid_a_q;
    logic [7:0]    sid_d_out_q;
    logic          sid_d_oe_q, sid_cs_q, sid_wr_q;
    logic          enq, deq, rd_acc;
    logic          start_rd, start_wr, load_go, cs_fall, finish, done_go;

    assign cnt_d      = cnt_q + 5'd1;
    assign fifo_full  = (count_q == FULL_CNT);
    assign fifo_empty = (count_q == '0);
    assign enq        = wr_stb && !fifo_full;
    assign rd_acc     = rd_stb && !rd_pend_q;
    assign deq        = start_wr;

    assign rd_data   = rd_data_q;
    assign rd_done   = rd_done_q;
    assign n_wait    = n_wait_q;
    assign overflow  = overflow_q;
    assign sid_clk   = cnt_q[4];
    assign sid_rst   = rst_n;
    assign sid_a     = sid_a_q;
    assign sid_d_out = sid_d_out_q;
    assign sid_d_oe  = sid_d_oe_q;
    assign sid_cs    = sid_cs_q;
    assign sid_wr    = sid_wr_q;

    // Queue occupancy and the count of writes that must finish before the pending read.
    // ahead_q snapshots the post-edge occupancy at read acceptance, so a write in the
    // same cycle is counted ahead and later writes are serviced after the read.
    always_comb begin
        count_d = count_q;
        unique case ({enq, deq})
            2'b10:   count_d = count_q + C_ONE;
            2'b01:   count_d = count_q - C_ONE;
            default: count_d = count_q;
        endcase
        ahead_d = ahead_q;
        if (rd_acc)
            ahead_d = count_d;
        else if (rd_pend_q && deq)
            ahead_d = ahead_q - C_ONE;
        rd_pend_d = rd_pend_q;
        if (rd_acc)
            rd_pend_d = 1'b1;
        else if (finish && op_rd_q)
            rd_pend_d = 1'b0;
    end

    // Access sequencer next-state and per-state action strobes.
    always_comb begin
        state_d  = state_q;
        start_rd = 1'b0;
        start_wr = 1'b0;
        load_go  = 1'b0;
        cs_fall  = 1'b0;
        finish   = 1'b0;
        done_go  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (rd_pend_q && (ahead_q == '0)) begin
                    start_rd = 1'b1;
                    state_d  = S_LOAD;
                end else if (!fifo_empty) begin
                    start_wr = 1'b1;
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                load_go = 1'b1;
                state_d = S_ARM;
            end
            S_ARM: begin
                if (cnt_d == CS_CNT) begin
                    cs_fall = 1'b1;
                    state_d = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (cnt_d == '0) begin
                    finish  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_go = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk32 or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Queue storage; validity is tracked by the pointers, so no reset is needed.
    always_ff @(posedge clk32) begin
        if (enq) mem_q[wptr_q] <= {wr_addr, wr_data};
    end

    // SID clock divider, queue pointers and read bookkeeping.
    always_ff @(posedge clk32 or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= 5'd16;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            ahead_q    <= '0;
            rd_pend_q  <= 1'b0;
            rd_addr_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            count_q   <= count_d;
            ahead_q   <= ahead_d;
            rd_pend_q <= rd_pend_d;
            if (enq) wptr_q <= wptr_q + P_ONE;
            if (deq) rptr_q <= rptr_q + P_ONE;
            if (wr_stb && fifo_full) overflow_q <= 1'b1;
            if (rd_acc) rd_addr_q <= rd_addr;
        end
    end

    // Operation latch and SID bus pin drivers.
    always_ff @(posedge clk32 or negedge rst_n) begin
        if (!rst_n) begin
            op_rd_q     <= 1'b0;
            op_a_q      <= '0;
            op_d_q      <= '0;
            sid_a_q     <= '0;
            sid_d_out_q <= '0;
            sid_d_oe_q  <= 1'b0;
            sid_cs_q    <= 1'b1;
            sid_wr_q    <= 1'b1;
            rd_data_q   <= '0;
            rd_done_q   <= 1'b0;
            n_wait_q    <= 1'b1;
        end else begin
            rd_done_q <= 1'b0;
            if (rd_acc) n_wait_q <= 1'b0;
            if (start_rd) begin
                op_rd_q <= 1'b1;
                op_a_q  <= rd_addr_q;
                op_d_q  <= '0;
            end
            if (start_wr) begin
                op_rd_q          <= 1'b0;
                {op_a_q, op_d_q} <= mem_q[rptr_q];
            end
            if (load_go) begin
                sid_a_q <= op_a_q;
                if (!op_rd_q) begin
                    sid_d_out_q <= op_d_q;
                    sid_d_oe_q  <= 1'b1;
                    sid_wr_q    <= 1'b0;
                end
            end
            if (cs_fall) sid_cs_q <= 1'b0;
            if (finish) begin
                sid_cs_q <= 1'b1;
                sid_wr_q <= 1'b1;
                if (op_rd_q) begin
                    rd_data_q <= sid_d_in;
                    rd_done_q <= 1'b1;
                    n_wait_q  <= 1'b1;
                end
            end
            if (done_go) sid_d_oe_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sid_bus_master.sv
// Scoreboard bench for sid_bus_master: expected SID accesses are queued as
// requests are driven and checked when the DUT completes each chip-select cycle.
module tb_sid_bus_master;

    localparam int DEPTH = 4;
    localparam int CS    = 20;

    typedef struct packed {
        logic       rd;
        logic [4:0] a;
        logic [7:0] d;
    } txn_t;

    logic       clk32 = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_stb = 1'b0;
    logic [4:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       rd_stb = 1'b0;
    logic [4:0] rd_addr = '0;
    logic [7:0] sid_d_in = '0;
    logic [7:0] rd_data;
    logic       rd_done, n_wait, fifo_full, fifo_empty, overflow;
    logic       sid_clk, sid_rst, sid_d_oe, sid_cs, sid_wr;
    logic [4:0] sid_a;
    logic [7:0] sid_d_out;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    txn_t        sb[$];

    sid_bus_master #(.FIFO_DEPTH(DEPTH), .CS_START(CS)) dut (
        .clk32(clk32), .rst_n(rst_n),
        .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_stb(rd_stb), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_done(rd_done), .n_wait(n_wait),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .overflow(overflow),
        .sid_clk(sid_clk), .sid_rst(sid_rst), .sid_a(sid_a),
        .sid_d_out(sid_d_out), .sid_d_oe(sid_d_oe), .sid_d_in(sid_d_in),
        .sid_cs(sid_cs), .sid_wr(sid_wr)
    );

    always #5 clk32 = ~clk32;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference sid_clk counter and cycle count.
    logic [4:0]  m_cnt;
    int unsigned cyc = 0;
    always @(posedge clk32 or negedge rst_n) begin
        if (!rst_n) m_cnt <= 5'd16;
        else        m_cnt <= m_cnt + 5'd1;
    end
    always @(posedge clk32) cyc <= cyc + 1;

    // Bus monitor.
    logic        prev_cs = 1'b1, prev_wr = 1'b1, prev_oe = 1'b0;
    logic [4:0]  prev_a = '0;
    logic [7:0]  prev_d = '0;
    int unsigned lo_w = 0, n_falls = 0, last_fall_cyc = 0;
    txn_t        cur;
    always @(negedge clk32) begin
        if (!rst_n) begin
            prev_cs = 1'b1;
            lo_w    = 0;
        end else begin
            if (prev_cs && !sid_cs) begin
                n_falls++;
                last_fall_cyc = cyc;
                lo_w = 1;
                check("cs_fall_count", 32'(m_cnt), 32'(CS));
                check("sid_clk_at_fall", 32'(sid_clk), 32'(m_cnt[4]));
                if (sb.size() == 0) begin
                    check("unexpected_access", 32'(1), 32'(0));
                end else begin
                    cur = sb[0];
                    check("setup_addr", 32'(prev_a), 32'(cur.a));
                    check("addr_at_fall", 32'(sid_a), 32'(cur.a));
                    if (!cur.rd) begin
                        check("setup_data", 32'(prev_d), 32'(cur.d));
                        check("setup_wr_low", 32'(prev_wr), 32'(0));
                        check("setup_oe", 32'(prev_oe), 32'(1));
                    end else begin
                        check("read_nwait_low", 32'(n_wait), 32'(0));
                        check("read_oe_off", 32'(sid_d_oe), 32'(0));
                    end
                end
            end else if (!sid_cs) begin
                lo_w++;
            end else if (!prev_cs && sid_cs) begin
                check("cs_width", lo_w, 32'(12));
                check("cs_rise_count", 32'(m_cnt), 32'(0));
                if (sb.size() == 0) begin
                    check("unexpected_complete", 32'(1), 32'(0));
                end else begin
                    cur = sb.pop_front();
                    if (cur.rd) begin
                        check("rd_data", 32'(rd_data), 32'(cur.d));
                        check("rd_done_pulse", 32'(rd_done), 32'(1));
                        check("nwait_release", 32'(n_wait), 32'(1));
                    end else begin
                        check("wr_rise", 32'(sid_wr), 32'(1));
                        check("wr_data_hold", 32'(sid_d_out), 32'(cur.d));
                    end
                end
            end
            if (rd_done && !(!prev_cs && sid_cs))
                check("rd_done_spurious", 32'(1), 32'(0));
            prev_cs = sid_cs;
            prev_wr = sid_wr;
            prev_oe = sid_d_oe;
            prev_a  = sid_a;
            prev_d  = sid_d_out;
        end
    end

    // Drive one write for a cycle; expect_q says whether the access should appear.
    task automatic wr(input logic [4:0] a, input logic [7:0] d, input bit expect_q);
        wr_stb  = 1'b1;
        wr_addr = a;
        wr_data = d;
        if (expect_q) sb.push_back('{rd: 1'b0, a: a, d: d});
        @(negedge clk32);
        wr_stb = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, input bit expect_q);
        rd_stb  = 1'b1;
        rd_addr = a;
        if (expect_q) sb.push_back('{rd: 1'b1, a: a, d: sid_d_in});
        @(negedge clk32);
        rd_stb = 1'b0;
    endtask

    task automatic drain(input int unsigned budget);
        int unsigned n = 0;
        while ((sb.size() != 0 || !fifo_empty) && n < budget) begin
            @(negedge clk32);
            n++;
        end
        check("drain_timeout", 32'(n < budget), 32'(1));
        repeat (4) @(negedge clk32);
    endtask

    task automatic wait_cs_low(input int unsigned budget);
        int unsigned n = 0;
        while (sid_cs && n < budget) begin
            @(negedge clk32);
            n++;
        end
        check("cs_low_timeout", 32'(n < budget), 32'(1));
    endtask

    initial begin
        int unsigned n;
        int unsigned c0;
        int unsigned f0;

        // Reset values.
        repeat (2) @(negedge clk32);
        check("rst_cs", 32'(sid_cs), 32'(1));
        check("rst_wr", 32'(sid_wr), 32'(1));
        check("rst_oe", 32'(sid_d_oe), 32'(0));
        check("rst_a", 32'(sid_a), 32'(0));
        check("rst_dout", 32'(sid_d_out), 32'(0));
        check("rst_rd_data", 32'(rd_data), 32'(0));
        check("rst_rd_done", 32'(rd_done), 32'(0));
        check("rst_nwait", 32'(n_wait), 32'(1));
        check("rst_overflow", 32'(overflow), 32'(0));
        check("rst_empty", 32'(fifo_empty), 32'(1));
        check("rst_full", 32'(fifo_full), 32'(0));
        check("rst_sid_rst", 32'(sid_rst), 32'(0));
        check("rst_sid_clk", 32'(sid_clk), 32'(1));
        rst_n = 1'b1;
        @(negedge clk32);
        check("sid_rst_follow", 32'(sid_rst), 32'(1));

        // Single write.
        wr(5'h04, 8'h1F, 1'b1);
        drain(300);

        // Overflow: DUT busy with one write, then five more back to back.
        wr(5'h01, 8'hA0, 1'b1);
        wait_cs_low(100);
        wr(5'h02, 8'hA1, 1'b1);
        wr(5'h03, 8'hA2, 1'b1);
        wr(5'h05, 8'hA3, 1'b1);
        wr(5'h06, 8'hA4, 1'b1);
        check("fifo_full", 32'(fifo_full), 32'(1));
        wr(5'h07, 8'hA5, 1'b0);
        check("overflow_set", 32'(overflow), 32'(1));
        drain(600);
        check("overflow_sticky", 32'(overflow), 32'(1));

        // Read.
        sid_d_in = 8'hA5;
        rd(5'h1B, 1'b1);
        check("nwait_next_edge", 32'(n_wait), 32'(0));
        drain(300);

        // Writes before read, ignored second read, write while read pending.
        sid_d_in = 8'h5A;
        wr(5'h08, 8'h11, 1'b1);
        wr(5'h09, 8'h22, 1'b1);
        rd(5'h0A, 1'b1);
        rd(5'h0B, 1'b0);
        wr(5'h0C, 8'h33, 1'b1);
        drain(600);

        // Same-cycle write and read: write goes first.
        sid_d_in = 8'h3C;
        wr_stb  = 1'b1; wr_addr = 5'h0D; wr_data = 8'h44;
        rd_stb  = 1'b1; rd_addr = 5'h0E;
        sb.push_back('{rd: 1'b0, a: 5'h0D, d: 8'h44});
        sb.push_back('{rd: 1'b1, a: 5'h0E, d: 8'h3C});
        @(negedge clk32);
        wr_stb = 1'b0;
        rd_stb = 1'b0;
        drain(300);

        // Write arriving at count 19 waits for the next period.
        n = 0;
        while (m_cnt != 5'd19 && n < 40) begin
            @(negedge clk32);
            n++;
        end
        check("cnt19_timeout", 32'(n < 40), 32'(1));
        c0 = cyc;
        wr(5'h0F, 8'h77, 1'b1);
        drain(300);
        check("late_start_delay", last_fall_cyc - c0, 32'(33));

        // Reset in the middle of an access.
        wr(5'h10, 8'h99, 1'b1);
        wait_cs_low(100);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_cs", 32'(sid_cs), 32'(1));
        check("mid_rst_wr", 32'(sid_wr), 32'(1));
        check("mid_rst_oe", 32'(sid_d_oe), 32'(0));
        check("mid_rst_a", 32'(sid_a), 32'(0));
        sb.delete();
        repeat (2) @(negedge clk32);
        rst_n = 1'b1;
        f0 = n_falls;
        repeat (80) @(negedge clk32);
        check("no_access_after_rst", n_falls, f0);
        check("empty_after_rst", 32'(fifo_empty), 32'(1));

        // Still functional afterwards.
        wr(5'h11, 8'h01, 1'b1);
        drain(300);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
